// File: rtl/hs_pad_stream_rx_if.sv
// Stream link from the pad bridge to the HyperSpace input: 16-bit words
// with valid/ready handshake and an end-of-frame marker.
interface hs_pad_stream_rx_if;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/hs_pad_stream_rx.sv
// Pad-side byte receiver: flops the mprj_io byte stream, undoes the pin bit
// order, packs byte pairs into 16-bit words and buffers them for HyperSpace.
module hs_pad_stream_rx #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 RSTB,
  input  logic                 pad_in_valid,
  input  logic                 pad_in_last,
  input  logic [7:0]           pad_in_data,
  output logic                 pad_in_ready,
  output logic [10:0]          pad_oeb,
  hs_pad_stream_rx_if.master   m_axis,
  output logic                 odd_frame,
  output logic [CNT_W-1:0]     frame_bytes
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] READY_LIMIT = (PTR_W+1)'(DEPTH - 3);

  typedef enum logic {EMPTY = 1'b0, HALF = 1'b1} pack_state_e;

  // Only mprj_io[27] (pad_in_ready) is an output pad.
  assign pad_oeb = 11'h7FE;

  logic [7:0] pad_rev;
  logic       s_valid, s_last, s_rdy;
  logic [7:0] s_data;

  always_comb begin
    for (int i = 0; i < 8; i++) pad_rev[i] = pad_in_data[7-i];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock) begin
    if (RSTB) begin
      s_valid <= 1'b0;
      s_last  <= 1'b0;
      s_data  <= '0;
      s_rdy   <= 1'b0;
    end else begin
      s_valid <= pad_in_valid;
      s_last  <= pad_in_last;
      s_data  <= pad_rev;
      s_rdy   <= pad_in_ready;
    end
  end

  // A byte only counts if the pad side also saw ready when it was sampled.
  logic accept;
  assign accept = s_valid & s_rdy;

  pack_state_e state_q, state_d;
  logic [7:0]  low_q;
  logic        push, push_last, load_low, set_odd;
  logic [15:0] push_word;

  always_ff @(posedge clock) begin
    if (RSTB) begin
      state_q   <= EMPTY;
      low_q     <= '0;
      odd_frame <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_low) low_q <= s_data;
      if (set_odd)  odd_frame <= 1'b1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a variable unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    push_word = '0;
    push_last = 1'b0;
    load_low  = 1'b0;
    set_odd   = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          if (s_last) begin
            push      = 1'b1;
            push_word = {8'h00, s_data};
            push_last = 1'b1;
            set_odd   = 1'b1;
          end else begin
            load_low = 1'b1;
            state_d  = HALF;
          end
        end
      end
      HALF: begin
        if (accept) begin
          push      = 1'b1;
          push_word = {s_data, low_q};
          push_last = s_last;
          state_d   = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  logic [16:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_next;
  logic [16:0]      head;
  logic             pop;

  assign head            = mem[rd_ptr_q];
  assign m_axis.m_valid  = (count_q != '0);
  assign m_axis.m_data   = m_axis.m_valid ? head[15:0] : '0;
  assign m_axis.m_last   = m_axis.m_valid & head[16];
  assign pop             = m_axis.m_valid & m_axis.m_ready;
  assign count_next      = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

  // NOTE: the storage array has no reset; stale entries are unreachable
  // because the outputs are gated by count and the pointers are reset.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= {push_last, push_word};
  end

  always_ff @(posedge clock) begin
    if (RSTB) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pad_in_ready <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q      <= count_next;
      // Leave room for the byte in the pad flop and the one in S0.
      pad_in_ready <= (count_next <= READY_LIMIT);
    end
  end

  // The counter shows the full frame length for one cycle after the last byte.
  logic clr_pending;

  always_ff @(posedge clock) begin
    if (RSTB) begin
      frame_bytes <= '0;
      clr_pending <= 1'b0;
    end else begin
      clr_pending <= accept & s_last;
      if (accept)           frame_bytes <= clr_pending ? CNT_W'(1) : frame_bytes + CNT_W'(1);
      else if (clr_pending) frame_bytes <= '0;
    end
  end

endmodule

// File: tb/tb_hs_pad_stream_rx.sv
// Randomized bench for hs_pad_stream_rx: byte frames are packed by a
// queue-based reference and compared word by word at the stream output.
module tb_hs_pad_stream_rx;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             RSTB  = 1'b1;
  logic             pad_in_valid = 1'b0;
  logic             pad_in_last  = 1'b0;
  logic [7:0]       pad_in_data  = '0;
  logic             pad_in_ready;
  logic [10:0]      pad_oeb;
  logic             odd_frame;
  logic [CNT_W-1:0] frame_bytes;

  hs_pad_stream_rx_if axis_if ();

  hs_pad_stream_rx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock        (clock),
    .RSTB         (RSTB),
    .pad_in_valid (pad_in_valid),
    .pad_in_last  (pad_in_last),
    .pad_in_data  (pad_in_data),
    .pad_in_ready (pad_in_ready),
    .pad_oeb      (pad_oeb),
    .m_axis       (axis_if.master),
    .odd_frame    (odd_frame),
    .frame_bytes  (frame_bytes)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [7:0]  in_bytes [$];
  bit          in_last  [$];
  logic [16:0] exp_q    [$];
  int          fb_max;
  int          words;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Reference packing: bytes pair up within a frame, first byte low; a frame
  // ending on an unpaired byte yields {00, byte} carrying last.
  task automatic build_expected();
    bit         have_low = 0;
    logic [7:0] low = '0;
    exp_q.delete();
    for (int i = 0; i < in_bytes.size(); i++) begin
      if (have_low) begin
        exp_q.push_back({in_last[i], in_bytes[i], low});
        have_low = 0;
      end else if (in_last[i]) begin
        exp_q.push_back({1'b1, 8'h00, in_bytes[i]});
      end else begin
        low      = in_bytes[i];
        have_low = 1;
      end
    end
  endtask

  task automatic set_frame(input int n, input int mode);
    in_bytes.delete();
    in_last.delete();
    for (int i = 0; i < n; i++) begin
      in_bytes.push_back(mode == 0 ? 8'(i) : 8'($urandom_range(255)));
      in_last.push_back(i == n - 1);
    end
  endtask

  // Streams in_bytes with random valid gaps and random m_ready; m_ready is
  // held low for the first 'stall' cycles.
  task automatic run_stream(input int v_pct, input int r_pct, input int stall,
                            output int words_out);
    int idx = 0;
    int cyc = 0;
    int n   = in_bytes.size();
    int total;
    logic [16:0] e;
    build_expected();
    total     = exp_q.size();
    words_out = 0;
    fb_max    = 0;
    while (!(idx == n && exp_q.size() == 0) && cyc < 20000) begin
      @(negedge clock);
      cyc++;
      if (int'(frame_bytes) > fb_max) fb_max = int'(frame_bytes);
      axis_if.m_ready = (cyc <= stall) ? 1'b0 : ($urandom_range(99) < r_pct);
      if (axis_if.m_valid && axis_if.m_ready) begin
        if (exp_q.size() == 0) begin
          check("word_overrun", words_out + 1, total);
        end else begin
          e = exp_q.pop_front();
          check("word", {axis_if.m_last, axis_if.m_data}, e);
        end
        words_out++;
      end
      if (stall > 0 && cyc == stall) begin
        check("stall_ready_low", pad_in_ready, 1'b0);
        check("stall_no_overflow", idx <= 2 * DEPTH, 1'b1);
      end
      if (idx < n) begin
        pad_in_valid = ($urandom_range(99) < v_pct);
        pad_in_data  = rev8(in_bytes[idx]);
        pad_in_last  = in_last[idx];
      end else begin
        pad_in_valid = 1'b0;
        pad_in_last  = 1'b0;
      end
      if (pad_in_valid && pad_in_ready) idx++;
    end
    check("stream_complete", (idx == n && exp_q.size() == 0), 1'b1);
    pad_in_valid    = 1'b0;
    pad_in_last     = 1'b0;
    axis_if.m_ready = 1'b1;
    repeat (4) @(negedge clock);
    check("no_extra_word", axis_if.m_valid, 1'b0);
    check("fb_idle_zero", frame_bytes, '0);
  endtask

  initial begin
    int idx;
    axis_if.m_ready = 1'b0;

    // Reset with valid held high on the pads.
    pad_in_valid = 1'b1;
    pad_in_data  = 8'h5A;
    RSTB = 1'b1;
    repeat (5) @(negedge clock);
    check("rst_pad_in_ready", pad_in_ready, 1'b0);
    check("rst_m_valid", axis_if.m_valid, 1'b0);
    check("rst_m_data", axis_if.m_data, 16'h0000);
    check("rst_m_last", axis_if.m_last, 1'b0);
    check("rst_odd_frame", odd_frame, 1'b0);
    check("rst_frame_bytes", frame_bytes, '0);
    check("rst_pad_oeb", pad_oeb, 11'h7FE);
    RSTB = 1'b0;
    @(negedge clock);
    check("ready_after_release", pad_in_ready, 1'b1);
    pad_in_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("no_word_from_reset_bytes", axis_if.m_valid, 1'b0);

    // Even frame 01..04.
    in_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
    in_last  = '{0, 0, 0, 1};
    run_stream(100, 100, 0, words);
    check("even_words", words, 2);
    check("even_fb_max", fb_max, 4);
    check("even_odd_frame", odd_frame, 1'b0);

    // Odd frame AA BB CC.
    in_bytes = '{8'hAA, 8'hBB, 8'hCC};
    in_last  = '{0, 0, 1};
    run_stream(100, 100, 0, words);
    check("odd_words", words, 2);
    check("odd_fb_max", fb_max, 3);
    check("odd_frame_set", odd_frame, 1'b1);

    // odd_frame is sticky across a later even frame.
    in_bytes = '{8'h10, 8'h20};
    in_last  = '{0, 1};
    run_stream(70, 80, 0, words);
    check("sticky_words", words, 1);
    check("odd_frame_sticky", odd_frame, 1'b1);

    // Backpressure: ramp with m_ready held low, then released.
    set_frame(2048, 0);
    run_stream(100, 100, 40, words);
    check("ramp_words", words, 1024);

    // Random valid gaps and m_ready toggling.
    set_frame(2048, 1);
    run_stream(70, 60, 0, words);
    check("rand_words", words, 1024);

    // Reset after three bytes of a frame.
    axis_if.m_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 50 && idx < 3; c++) begin
      @(negedge clock);
      pad_in_valid = 1'b1;
      pad_in_data  = rev8(8'(8'h30 + idx));
      pad_in_last  = 1'b0;
      if (pad_in_valid && pad_in_ready) idx++;
    end
    @(negedge clock);
    pad_in_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("partial_frame_bytes", frame_bytes, 16'd3);
    check("partial_word_held", axis_if.m_valid, 1'b1);
    RSTB = 1'b1;
    repeat (2) @(negedge clock);
    RSTB = 1'b0;
    @(negedge clock);
    check("abort_m_valid", axis_if.m_valid, 1'b0);
    check("abort_frame_bytes", frame_bytes, '0);
    check("abort_odd_cleared", odd_frame, 1'b0);

    in_bytes = '{8'hE1, 8'hE2};
    in_last  = '{0, 1};
    run_stream(100, 100, 0, words);
    check("post_abort_words", words, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
